cross_comm_engine: RTL and testbench
====================================

CROSS_COMM_ENGINE -- requirements
Module: cross_comm_engine

Interface
REQ-001 SHALL have parameter N_LEGS, default 4, number of commodity legs (1..16).
REQ-002 SHALL have parameter RATE_W, default 16, outright rate width per leg.
REQ-003 SHALL have parameter RATIO_W, default 8, ratio width per leg.
REQ-004 SHALL have parameter PCT_W, default 8, inter-rate percentage width.
REQ-005 SHALL have parameter OUT_W, default 16, charge output width; derived ACC_W = RATE_W+RATIO_W+clog2(N_LEGS) and PROD_W = ACC_W+PCT_W.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, request present.
REQ-009 SHALL have port in_ready, output, 1, engine can accept request.
REQ-010 SHALL have port outright_rate, input, N_LEGS*RATE_W, leg i at bits [i*RATE_W +: RATE_W], unsigned.
REQ-011 SHALL have port ratio, input, N_LEGS*RATIO_W, leg i at bits [i*RATIO_W +: RATIO_W], unsigned.
REQ-012 SHALL have port inter_rate, input, PCT_W, percentage applied to margin, unsigned, values above 100 allowed.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port cross_comm_charge, output, OUT_W, final charge.
REQ-016 SHALL have port outright_margin, output, ACC_W, full-precision weighted margin.
REQ-017 SHALL have port overflow, output, 1, charge exceeded OUT_W range.
REQ-018 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, SCALE, DIVIDE, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; on in_valid&&in_ready, all inputs SHALL be registered and state SHALL go to ACCUM with leg index 0 and accumulator 0.
REQ-021 ACCUM SHALL add rate[i]*ratio[i] for one leg per cycle, i = 0..N_LEGS-1, then go to SCALE; the accumulator SHALL be ACC_W wide and never wrap.
REQ-022 SCALE SHALL compute product = accumulator*inter_rate in PROD_W bits in one cycle, then go to DIVIDE.
REQ-023 DIVIDE SHALL compute floor(product/100) with a restoring shift-subtract divider, one quotient bit per cycle, exactly PROD_W cycles, then go to DONE.
REQ-024 out_valid SHALL rise exactly N_LEGS+1+PROD_W cycles after the accept edge (39 at defaults).
REQ-025 In DONE, out_valid, cross_comm_charge, outright_margin and overflow SHALL hold stable until out_ready is sampled high; state SHALL then go to IDLE with out_valid 0 on the next cycle.
REQ-026 Changes on request inputs after the accept edge SHALL not affect the result in flight.
REQ-027 Legs with ratio 0 or rate 0 SHALL contribute 0; N_LEGS=1 SHALL be legal.
REQ-028 Outputs SHALL be registered; cross_comm_charge, outright_margin and overflow SHALL update only on entry to DONE.

Reset
REQ-029 When reset is high at a rising edge, state SHALL go to IDLE and in_ready SHALL become 1; out_valid, busy, overflow, cross_comm_charge, outright_margin, the accumulator and the divider registers SHALL all clear to 0.
REQ-030 A reset in any non-IDLE state SHALL abort the operation with no out_valid pulse; the first request after reset deasserts SHALL be accepted normally.

Configuration
REQ-031 With CROSS_COMM_SAT_EN defined, a quotient above 2^OUT_W-1 SHALL give cross_comm_charge = 2^OUT_W-1 and overflow = 1.
REQ-032 Without CROSS_COMM_SAT_EN, cross_comm_charge SHALL be the low OUT_W bits of the quotient and overflow SHALL be constant 0.

Verification (defaults)
REQ-033 Basic: rates {1000,2000,0,0}, ratios {2,1,0,0}, inter_rate 50 -> margin 4000, charge 2000, out_valid 39 cycles after accept.
REQ-034 Floor: rate0 3, ratio0 1, other legs 0, inter_rate 33 -> margin 3, charge 0; inter_rate 34 -> charge 1.
REQ-035 Overflow: all rates 65535, all ratios 255, inter_rate 255 -> margin 66845700; with CROSS_COMM_SAT_EN, charge 65535 and overflow 1; without it, charge 62935 and overflow 0.
REQ-036 Backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-037 Reset mid-DIVIDE -> no out_valid, all outputs 0; the next request (REQ-033 values) gives charge 2000.
REQ-038 Input change: inputs changed every cycle after accept -> result equals the values captured at accept.

Source files
------------

// File: rtl/cross_comm_engine.sv
// Cross-commodity margin engine: weighted leg sum, percentage scale, divide by 100.
// Optional build macro CROSS_COMM_SAT_EN saturates the charge and flags overflow.
module cross_comm_engine #(
    parameter int N_LEGS  = 4,
    parameter int RATE_W  = 16,
    parameter int RATIO_W = 8,
    parameter int PCT_W   = 8,
    parameter int OUT_W   = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [N_LEGS*RATE_W-1:0]                          outright_rate,
    input  logic [N_LEGS*RATIO_W-1:0]                         ratio,
    input  logic [PCT_W-1:0]                                  inter_rate,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [OUT_W-1:0]                                  cross_comm_charge,
    output logic [RATE_W+RATIO_W+$clog2(N_LEGS)-1:0]          outright_margin,
    output logic                                              overflow,
    output logic                                              busy
);
    // state  | meaning
    // IDLE   | waiting for a request, in_ready high
    // ACCUM  | adding one leg's rate*ratio per cycle
    // SCALE  | margin * inter_rate
    // DIVIDE | restoring divide by 100, one quotient bit per cycle
    // DONE   | result held until out_ready
    localparam int ACC_W  = RATE_W + RATIO_W + $clog2(N_LEGS);
    localparam int PROD_W = ACC_W + PCT_W;
    localparam int MUL_W  = RATE_W + RATIO_W;
    localparam int IDX_W  = (N_LEGS > 1) ? $clog2(N_LEGS) : 1;
    localparam int CNT_W  = $clog2(PROD_W + 1);
    localparam logic [7:0] DIVISOR = 8'd100;

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, DIVIDE, DONE} state_t;
    state_t state, state_nxt;

    logic [N_LEGS*RATE_W-1:0]  rate_r;
    logic [N_LEGS*RATIO_W-1:0] ratio_r;
    logic [PCT_W-1:0]          ir_r;
    logic [IDX_W-1:0]          leg;
    logic [ACC_W-1:0]          acc;
    logic [PROD_W-1:0]         prod;
    logic [7:0]                rem;
    logic [CNT_W-1:0]          cnt;

    logic [MUL_W-1:0]  leg_prod;
    logic [7:0]        trial;
    logic              q_bit;
    logic [7:0]        rem_nxt;
    logic [PROD_W-1:0] quot_nxt;
    logic [OUT_W-1:0]  charge_nxt;
    logic              ovf_nxt;
    logic              leg_last;
    logic              cnt_tc;

    assign leg_last = (leg == IDX_W'(N_LEGS - 1));
    assign cnt_tc   = (cnt == '0);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // The remainder stays below 100, so one shifted-in bit fits in 8 bits.
    always_comb begin
        leg_prod = rate_r[leg*RATE_W +: RATE_W] * ratio_r[leg*RATIO_W +: RATIO_W];
        trial    = {rem[6:0], prod[PROD_W-1]};
        q_bit    = (trial >= DIVISOR);
        rem_nxt  = q_bit ? (trial - DIVISOR) : trial;
        quot_nxt = {prod[PROD_W-2:0], q_bit};
    end

`ifdef CROSS_COMM_SAT_EN
    logic [PROD_W+OUT_W-1:0] quot_ext;
    always_comb begin
        quot_ext   = (PROD_W+OUT_W)'(quot_nxt);
        ovf_nxt    = |quot_ext[PROD_W+OUT_W-1:OUT_W];
        charge_nxt = ovf_nxt ? {OUT_W{1'b1}} : quot_ext[OUT_W-1:0];
    end
`else
    always_comb begin
        ovf_nxt    = 1'b0;
        charge_nxt = OUT_W'(quot_nxt);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACCUM;
            ACCUM:   if (leg_last) state_nxt = SCALE;
            SCALE:   state_nxt = DIVIDE;
            DIVIDE:  if (cnt_tc) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_r            <= '0;
            ratio_r           <= '0;
            ir_r              <= '0;
            leg               <= '0;
            acc               <= '0;
            prod              <= '0;
            rem               <= '0;
            cnt               <= '0;
            out_valid         <= 1'b0;
            cross_comm_charge <= '0;
            outright_margin   <= '0;
            overflow          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    rate_r  <= outright_rate;
                    ratio_r <= ratio;
                    ir_r    <= inter_rate;
                    leg     <= '0;
                    acc     <= '0;
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(leg_prod);
                    leg <= leg + 1'b1;
                end
                SCALE: begin
                    prod <= PROD_W'(acc) * PROD_W'(ir_r);
                    rem  <= '0;
                    cnt  <= CNT_W'(PROD_W - 1);
                end
                DIVIDE: begin
                    // prod doubles as the quotient register as bits shift out the top
                    prod <= quot_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt_tc) begin
                        out_valid         <= 1'b1;
                        cross_comm_charge <= charge_nxt;
                        outright_margin   <= acc;
                        overflow          <= ovf_nxt;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cross_comm_engine.sv
// Directed bench for cross_comm_engine at default parameters.
module tb_cross_comm_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] outright_rate;
    logic [31:0] ratio;
    logic [7:0]  inter_rate;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cross_comm_charge;
    logic [25:0] outright_margin;
    logic        overflow;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int seen;

    cross_comm_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .outright_rate(outright_rate), .ratio(ratio), .inter_rate(inter_rate),
        .out_valid(out_valid), .out_ready(out_ready),
        .cross_comm_charge(cross_comm_charge), .outright_margin(outright_margin),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] r, input logic [31:0] q, input logic [7:0] ir,
                         input bit scramble, output int latency);
        outright_rate = r;
        ratio         = q;
        inter_rate    = ir;
        in_valid      = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 200) begin
            if (scramble) begin
                outright_rate = {$urandom, $urandom};
                ratio         = $urandom;
                inter_rate    = 8'($urandom);
                in_valid      = 1'($urandom);
            end
            tick();
            latency++;
        end
        in_valid = 1'b0;
        check("out_valid_latency", latency, 39);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        outright_rate = '0; ratio = '0; inter_rate = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_charge", cross_comm_charge, 0);
        check("rst_margin", outright_margin, 0);
        check("rst_overflow", overflow, 0);

        // basic
        issue({16'd0, 16'd0, 16'd2000, 16'd1000}, {8'd0, 8'd0, 8'd1, 8'd2}, 8'd50, 1'b0, lat);
        check("basic_margin", outright_margin, 4000);
        check("basic_charge", cross_comm_charge, 2000);
        check("basic_overflow", overflow, 0);
        check("basic_busy", busy, 1);
        consume();

        // all four legs weighted differently: 10+40+90+160
        issue({16'd40, 16'd30, 16'd20, 16'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd100, 1'b0, lat);
        check("legs_margin", outright_margin, 300);
        check("legs_charge", cross_comm_charge, 300);
        consume();

        // floor
        issue({48'd0, 16'd3}, {24'd0, 8'd1}, 8'd33, 1'b0, lat);
        check("floor33_margin", outright_margin, 3);
        check("floor33_charge", cross_comm_charge, 0);
        consume();
        issue({48'd0, 16'd3}, {24'd0, 8'd1}, 8'd34, 1'b0, lat);
        check("floor34_charge", cross_comm_charge, 1);
        consume();

        // overflow
        issue({4{16'hFFFF}}, {4{8'hFF}}, 8'd255, 1'b0, lat);
        check("ovf_margin", outright_margin, 66845700);
`ifdef CROSS_COMM_SAT_EN
        check("ovf_charge", cross_comm_charge, 65535);
        check("ovf_flag", overflow, 1);
`else
        check("ovf_charge", cross_comm_charge, 62935);
        check("ovf_flag", overflow, 0);
`endif
        consume();

        // backpressure
        issue({16'd0, 16'd0, 16'd2000, 16'd1000}, {8'd0, 8'd0, 8'd1, 8'd2}, 8'd50, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_charge", cross_comm_charge, 2000);
            check("bp_margin", outright_margin, 4000);
            check("bp_in_ready", in_ready, 0);
        end
        consume();

        // reset mid-divide
        outright_rate = {16'd0, 16'd0, 16'd0, 16'd500};
        ratio         = {8'd0, 8'd0, 8'd0, 8'd3};
        inter_rate    = 8'd77;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_charge", cross_comm_charge, 0);
        check("abort_margin", outright_margin, 0);
        check("abort_overflow", overflow, 0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        issue({16'd0, 16'd0, 16'd2000, 16'd1000}, {8'd0, 8'd0, 8'd1, 8'd2}, 8'd50, 1'b0, lat);
        check("post_reset_charge", cross_comm_charge, 2000);
        consume();

        // inputs scrambled after accept
        issue({16'd0, 16'd0, 16'd2000, 16'd1000}, {8'd0, 8'd0, 8'd1, 8'd2}, 8'd50, 1'b1, lat);
        check("scramble_margin", outright_margin, 4000);
        check("scramble_charge", cross_comm_charge, 2000);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
